histo_read_sched: RTL and testbench

HISTO_READ_SCHED -- requirements
Module: histo_read_sched

---
 rtl/histo_read_sched_pkg.sv | 22 ++
 rtl/histo_read_sched_peak.sv | 29 ++
 rtl/histo_read_sched.sv | 149 ++++++++++++++
 tb/tb_histo_read_sched.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/histo_read_sched_pkg.sv
// Shared widths, FSM state and response tag encodings for the histogram read scheduler.
package histo_read_sched_pkg;

  localparam int unsigned HistoAddrW = 8;
  localparam int unsigned HistoDataW = 20;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSweep = 2'd1,
    StDrain = 2'd2,
    StServe = 2'd3
  } state_e;

  // TagSweep marks peak-sweep reads so they never surface as requester responses.
  typedef enum logic [1:0] {
    TagNone  = 2'd0,
    TagA     = 2'd1,
    TagB     = 2'd2,
    TagSweep = 2'd3
  } tag_e;

endpackage

// File: rtl/histo_read_sched_peak.sv
// Running argmax over sweep responses; strictly-greater update keeps the lowest index on ties.
module histo_peak_tracker #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 20
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iClear,
  input  logic              iValid,
  input  logic [ADDR_W-1:0] iBin,
  input  logic [DATA_W-1:0] iCount,
  output logic [ADDR_W-1:0] oPeakBin,
  output logic [DATA_W-1:0] oPeakCount
);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oPeakBin   <= '0;
      oPeakCount <= '0;
    end else if (iClear) begin
      oPeakBin   <= '0;
      oPeakCount <= '0;
    end else if (iValid && (iCount > oPeakCount)) begin
      oPeakBin   <= iBin;
      oPeakCount <= iCount;
    end
  end

endmodule

// File: rtl/histo_read_sched.sv
// Shares one histogram read port between a full peak sweep and two round-robin requesters.
module histo_read_sched
  import histo_read_sched_pkg::*;
#(
  parameter int unsigned ADDR_W   = HistoAddrW,
  parameter int unsigned DATA_W   = HistoDataW,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iDone,
  output logic [ADDR_W-1:0] oReadGray,
  input  logic [DATA_W-1:0] iGrayHisto,
  input  logic [DATA_W-1:0] iGrayCumHisto,
  input  logic              iReqA,
  input  logic              iReqB,
  input  logic [ADDR_W-1:0] iAddrA,
  input  logic [ADDR_W-1:0] iAddrB,
  output logic              oGntA,
  output logic              oGntB,
  output logic              oValidA,
  output logic              oValidB,
  output logic [DATA_W-1:0] oHisto,
  output logic [DATA_W-1:0] oCumHisto,
  output logic [ADDR_W-1:0] oPeakBin,
  output logic [DATA_W-1:0] oPeakCount,
  output logic              oPeakValid
);

  state_e            state_q;
  logic              done_q;
  logic              rr_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] rbin_q;
  logic [2:0]        drain_q;
  tag_e              tag_q [READ_LAT];
  tag_e              tag_in;
  logic              serve, sweep_start, sweep_last, drain_last, sweep_rsp;

  assign serve       = (state_q == StServe) && iDone;
  assign sweep_start = (state_q == StIdle) && iDone && !done_q;
  assign sweep_last  = (cnt_q == {ADDR_W{1'b1}});
  assign drain_last  = (drain_q == 3'(READ_LAT - 1));
  assign sweep_rsp   = iDone && (tag_q[READ_LAT-1] == TagSweep);

  assign oValidA   = iDone && (tag_q[READ_LAT-1] == TagA);
  assign oValidB   = iDone && (tag_q[READ_LAT-1] == TagB);
  assign oHisto    = iGrayHisto;
  assign oCumHisto = iGrayCumHisto;

  always_comb begin
    oGntA = 1'b0;
    oGntB = 1'b0;
    if (serve) begin
      if (iReqA && iReqB) begin
        oGntA = !rr_q;
        oGntB = rr_q;
      end else begin
        oGntA = iReqA;
        oGntB = iReqB;
      end
    end
  end

  always_comb begin
    oReadGray = addr_q;
    tag_in    = TagNone;
    if (state_q == StSweep) begin
      oReadGray = cnt_q;
      tag_in    = TagSweep;
    end else if (oGntA) begin
      oReadGray = iAddrA;
      tag_in    = TagA;
    end else if (oGntB) begin
      oReadGray = iAddrB;
      tag_in    = TagB;
    end
  end

  // done_q resets high so a level-high iDone after reset is not taken as a new rising edge.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q    <= StIdle;
      done_q     <= 1'b1;
      rr_q       <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      rbin_q     <= '0;
      drain_q    <= '0;
      oPeakValid <= 1'b0;
      for (int i = 0; i < READ_LAT; i++) tag_q[i] <= TagNone;
    end else begin
      done_q <= iDone;
      addr_q <= oReadGray;
      tag_q[0] <= iDone ? tag_in : TagNone;
      for (int i = 1; i < READ_LAT; i++) tag_q[i] <= iDone ? tag_q[i-1] : TagNone;
      if (serve && iReqA && iReqB) rr_q <= !rr_q;
      if (sweep_start) rbin_q <= '0;
      else if (sweep_rsp) rbin_q <= rbin_q + ADDR_W'(1);
      if (!iDone) begin
        state_q    <= StIdle;
        oPeakValid <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (!done_q) begin
              state_q <= StSweep;
              cnt_q   <= '0;
            end
          end
          StSweep: begin
            if (sweep_last) begin
              state_q <= StDrain;
              drain_q <= '0;
            end else begin
              cnt_q <= cnt_q + ADDR_W'(1);
            end
          end
          StDrain: begin
            if (drain_last) begin
              state_q    <= StServe;
              oPeakValid <= 1'b1;
            end else begin
              drain_q <= drain_q + 3'd1;
            end
          end
          StServe: state_q <= StServe;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  histo_peak_tracker #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_peak (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .iClear    (sweep_start),
    .iValid    (sweep_rsp),
    .iBin      (rbin_q),
    .iCount    (iGrayHisto),
    .oPeakBin  (oPeakBin),
    .oPeakCount(oPeakCount)
  );

endmodule

// File: tb/tb_histo_read_sched.sv
// Randomized bench for histo_read_sched against a cycle-indexed behavioural model.
module tb_histo_read_sched;

  localparam int LAT     = 2;
  localparam int DW      = 20;
  localparam int ServeAt = 256 + LAT;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          done_in = 1'b0;
  logic [7:0]    read_gray;
  logic [DW-1:0] gray_histo, gray_cum;
  logic          req_a = 1'b0, req_b = 1'b0;
  logic [7:0]    addr_a = '0, addr_b = '0;
  logic          gnt_a, gnt_b, valid_a, valid_b, peak_valid;
  logic [DW-1:0] histo, cum_histo, peak_count;
  logic [7:0]    peak_bin;

  logic [DW-1:0] mem [256];
  logic [DW-1:0] cum [256];
  logic [7:0]    apipe [LAT];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  histo_read_sched #(
    .ADDR_W  (8),
    .DATA_W  (DW),
    .READ_LAT(LAT)
  ) dut (
    .iClk         (clk),
    .iRst_n       (rst_n),
    .iDone        (done_in),
    .oReadGray    (read_gray),
    .iGrayHisto   (gray_histo),
    .iGrayCumHisto(gray_cum),
    .iReqA        (req_a),
    .iReqB        (req_b),
    .iAddrA       (addr_a),
    .iAddrB       (addr_b),
    .oGntA        (gnt_a),
    .oGntB        (gnt_b),
    .oValidA      (valid_a),
    .oValidB      (valid_b),
    .oHisto       (histo),
    .oCumHisto    (cum_histo),
    .oPeakBin     (peak_bin),
    .oPeakCount   (peak_count),
    .oPeakValid   (peak_valid)
  );

  // Histogram memory with LAT-cycle read latency.
  always @(posedge clk) begin
    apipe[0] <= read_gray;
    for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign gray_histo = mem[apipe[LAT-1]];
  assign gray_cum   = cum[apipe[LAT-1]];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void calc_cum();
    logic [DW-1:0] s = '0;
    for (int i = 0; i < 256; i++) begin
      s = s + mem[i];
      cum[i] = s;
    end
  endfunction

  function automatic void argmax(output int b, output int c);
    b = 0;
    c = 0;
    for (int i = 0; i < 256; i++) if (int'(mem[i]) > c) begin
      b = i;
      c = int'(mem[i]);
    end
  endfunction

  // ---------------- behavioural model + compare ----------------
  typedef struct {
    int due;
    bit is_b;
    int addr;
  } beat_t;

  beat_t m_q[$];
  int    m_since = -1;
  bit    m_done_prev = 1'b1;
  bit    m_rr = 1'b0;
  int    m_last = 0;
  int    cyc = 0;
  int    m_pk_bin = 0, m_pk_cnt = 0;

  always @(negedge clk) begin : model
    bit    srv, ga, gb, va, vb, pv;
    int    ea;
    beat_t b;
    cyc++;
    if (!rst_n) begin
      chk("rst_gray", read_gray, 0);
      chk("rst_gnt", {gnt_a, gnt_b}, 0);
      chk("rst_valid", {valid_a, valid_b}, 0);
      chk("rst_peak", {peak_valid, peak_bin, peak_count}, 0);
      m_q.delete();
      m_since = -1;
      m_done_prev = 1'b1;
      m_rr = 1'b0;
      m_last = 0;
    end else begin
      srv = done_in && (m_since >= ServeAt);
      ga = 1'b0;
      gb = 1'b0;
      if (srv) begin
        if (req_a && req_b) begin
          ga = !m_rr;
          gb = m_rr;
        end else begin
          ga = req_a;
          gb = req_b;
        end
      end
      if (m_since >= 0 && m_since < 256) ea = m_since;
      else if (ga) ea = int'(addr_a);
      else if (gb) ea = int'(addr_b);
      else ea = m_last;
      pv = (m_since >= ServeAt);
      va = 1'b0;
      vb = 1'b0;
      if (m_q.size() != 0 && m_q[0].due == cyc) begin
        b = m_q.pop_front();
        va = done_in && !b.is_b;
        vb = done_in && b.is_b;
      end
      chk("gnt_a", gnt_a, ga);
      chk("gnt_b", gnt_b, gb);
      chk("read_gray", read_gray, ea);
      chk("valid_a", valid_a, va);
      chk("valid_b", valid_b, vb);
      chk("peak_valid", peak_valid, pv);
      if (va || vb) begin
        chk("histo", histo, mem[b.addr]);
        chk("cum_histo", cum_histo, cum[b.addr]);
      end
      if (pv) begin
        chk("peak_bin", peak_bin, m_pk_bin);
        chk("peak_count", peak_count, m_pk_cnt);
      end
      if (ga || gb) m_q.push_back('{due: cyc + LAT, is_b: gb, addr: ea});
      if (srv && req_a && req_b) m_rr = !m_rr;
      m_last = ea;
      if (!done_in) begin
        m_since = -1;
        m_q.delete();
      end else if (m_since < 0) begin
        if (!m_done_prev) begin
          m_since = 0;
          argmax(m_pk_bin, m_pk_cnt);
        end
      end else if (m_since < 1000000) begin
        m_since++;
      end
      m_done_prev = done_in;
    end
  end

  // Event logs for the directed literal checks.
  int glog[$];
  int vlog_who[$];
  int vlog_h[$];
  always @(negedge clk) begin
    if (gnt_a) glog.push_back(1);
    if (gnt_b) glog.push_back(2);
    if (valid_a) begin
      vlog_who.push_back(1);
      vlog_h.push_back(int'(histo));
    end
    if (valid_b) begin
      vlog_who.push_back(2);
      vlog_h.push_back(int'(histo));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    glog.delete();
    vlog_who.delete();
    vlog_h.delete();
  endtask

  task automatic wait_pv(input string name, output int n);
    n = 0;
    while (n < 600) begin
      @(negedge clk);
      n++;
      if (peak_valid) break;
    end
    chk(name, peak_valid, 1);
  endtask

  initial begin
    int n, na, nb;
    for (int i = 0; i < 256; i++) mem[i] = DW'(i);
    calc_cum();

    // Reset, then first sweep over bin i = i
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    done_in = 1'b1;
    wait_pv("sweep1_pv", n);
    chk("sweep1_latency", n, 258 + LAT);
    chk("sweep1_peak_bin", peak_bin, 255);
    chk("sweep1_peak_cnt", peak_count, 255);
    tick();

    // Contested requests alternate starting with A
    clear_logs();
    req_a = 1'b1; addr_a = 8'd5;
    req_b = 1'b1; addr_b = 8'd9;
    repeat (6) tick();
    req_a = 1'b0; req_b = 1'b0;
    repeat (LAT + 2) tick();
    chk("rr_grants", glog.size(), 6);
    chk("rr_valids", vlog_h.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < glog.size()) chk("rr_gnt_order", glog[i], (i % 2) ? 2 : 1);
      if (i < vlog_h.size()) begin
        chk("rr_valid_who", vlog_who[i], (i % 2) ? 2 : 1);
        chk("rr_histo", vlog_h[i], (i % 2) ? 9 : 5);
      end
    end

    // Sole requester A gets every cycle
    clear_logs();
    req_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      addr_a = 8'(i);
      tick();
    end
    req_a = 1'b0;
    repeat (LAT + 2) tick();
    na = 0; nb = 0;
    foreach (glog[i]) if (glog[i] == 1) na++; else nb++;
    chk("solo_gnt_a", na, 10);
    chk("solo_gnt_b", nb, 0);
    na = 0; nb = 0;
    foreach (vlog_who[i]) if (vlog_who[i] == 1) na++; else nb++;
    chk("solo_valid_a", na, 10);
    chk("solo_valid_b", nb, 0);
    for (int i = 0; i < 10; i++) if (i < vlog_h.size()) chk("solo_histo", vlog_h[i], i);

    // iDone drops right after a granted beat
    clear_logs();
    req_a = 1'b1; addr_a = 8'd3;
    tick();
    done_in = 1'b0;
    @(negedge clk);
    chk("drop_gnt", gnt_a, 0);
    tick();
    @(negedge clk);
    chk("drop_pv", peak_valid, 0);
    tick();
    req_a = 1'b0;
    repeat (LAT + 2) tick();
    chk("drop_grants", glog.size(), 1);
    chk("drop_no_valid", vlog_who.size(), 0);

    // Tie histogram: lowest index wins
    for (int i = 0; i < 256; i++) mem[i] = DW'(7);
    mem[40] = DW'(900);
    mem[200] = DW'(900);
    calc_cum();
    done_in = 1'b1;
    wait_pv("tie_pv", n);
    chk("tie_peak_bin", peak_bin, 40);
    chk("tie_peak_cnt", peak_count, 900);
    tick();

    // Reset mid-sweep at address 100 with iDone held high
    done_in = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom_range(0, 1000));
    calc_cum();
    done_in = 1'b1;
    n = 0;
    while (n < 400 && read_gray != 8'd100) begin
      tick();
      n++;
    end
    chk("reach_addr100", read_gray, 100);
    rst_n = 1'b0;
    #1;
    chk("async_rst_gray", read_gray, 0);
    chk("async_rst_peak", {peak_valid, peak_bin, peak_count}, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("post_rst_idle_gray", read_gray, 0);
    chk("post_rst_idle_pv", peak_valid, 0);
    done_in = 1'b0;
    repeat (2) tick();
    done_in = 1'b1;
    wait_pv("rand_pv", n);
    tick();

    // Random serve traffic
    for (int i = 0; i < 300; i++) begin
      req_a  = 1'($urandom_range(0, 1));
      req_b  = 1'($urandom_range(0, 1));
      addr_a = 8'($urandom_range(0, 255));
      addr_b = 8'($urandom_range(0, 255));
      tick();
    end
    req_a = 1'b0; req_b = 1'b0;
    repeat (LAT + 2) tick();
    done_in = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
